sinc3_decimator: RTL and testbench

- Receive-side decoder for the second-order sigma-delta bitstream. Converts the 1-bit modulator output into signed multibit PCM samples with a sinc3 (3rd-order CIC) decimator.
- Sits after second_order_sigdel_virtualized, in parallel with reconstruction_filter.
- Provides decimated samples with a valid strobe so the test harness and downstream logic can compare the result against the lattice_sine_table source.

---
 rtl/sinc3_decimator.sv | 93 +++++++++
 tb/tb_sinc3_decimator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sinc3_decimator.sv
// rtl/sinc3_decimator.sv - sinc3 (3rd-order CIC) decimator for a 1-bit sigma-delta stream
module sinc3_decimator #(
  parameter int LOG2_R    = 6,
  parameter int OUT_WIDTH = 24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        bitstream_in,
  input  logic                        bitstream_valid,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid,
  output logic                        settled
);

  localparam int W = 3*LOG2_R + 2;

  logic signed [W-1:0] s;
  logic signed [W-1:0] i1, i2, i3;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] c1, c2, c3;
  logic signed [W-1:0] comb_q;
  logic [LOG2_R-1:0]   count;
  logic                decim_tick;
  logic                comb_tick;
  logic [1:0]          discard;

  // Bit 1 maps to +1, bit 0 to -1; wrap in the integrators is exact for CIC.
  assign s  = bitstream_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

  assign c1 = i3 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      count      <= '0;
      decim_tick <= 1'b0;
    end else begin
      decim_tick <= 1'b0;
      if (bitstream_valid) begin
        i1         <= i1 + s;
        i2         <= i2 + i1;
        i3         <= i3 + i2;
        count      <= count + 1'b1;
        decim_tick <= &count;
      end
    end
  end

  // Combs run at the decimated rate, sampling i3 right after the R-th bit landed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      comb_q    <= '0;
      comb_tick <= 1'b0;
    end else begin
      comb_tick <= decim_tick;
      if (decim_tick) begin
        d1     <= i3;
        d2     <= c1;
        d3     <= c2;
        comb_q <= c3;
      end
    end
  end

  // The first three results are transient (filter still filling) and stay unflagged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      settled   <= 1'b0;
      discard   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (comb_tick) begin
        out <= OUT_WIDTH'(comb_q);
        if (discard != 2'd3) begin
          discard <= discard + 2'd1;
        end else begin
          out_valid <= 1'b1;
          settled   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sinc3_decimator.sv
// tb/tb_sinc3_decimator.sv - directed vector bench for sinc3_decimator
module tb_sinc3_decimator;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               bitstream_in = 1'b0;
  logic               bitstream_valid = 1'b0;
  logic signed [23:0] out;
  logic               out_valid;
  logic               settled;

  int errors = 0;
  int checks = 0;

  sinc3_decimator #(.LOG2_R(6), .OUT_WIDTH(24)) dut (
    .clock           (clock),
    .reset           (reset),
    .bitstream_in    (bitstream_in),
    .bitstream_valid (bitstream_valid),
    .out             (out),
    .out_valid       (out_valid),
    .settled         (settled)
  );

  always #5 clock = ~clock;

  // pat: 0 ones, 1 zeros, 2 alternating 1,0, 3 repeating 1,1,1,0, 4 repeating 1,0,0,0
  typedef struct {
    int pat;
    bit gate;
    int gap;
    int p1;
    int p2;
    int p3;
    int val;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k % 2) == 0;
      3:       return (k % 4) != 3;
      default: return (k % 4) == 0;
    endcase
  endfunction

  task automatic step(input logic b, input logic v);
    bitstream_in    = b;
    bitstream_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bitstream_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Cycle c (1-based) is the c-th clock edge after the call; records the first 3 pulses.
  task automatic run_vec(input int idx, input vec_t v);
    int pc[3];
    int pv[3];
    int np = 0;
    int k = 0;
    bit early = 1'b0;
    logic vb;
    for (int i = 0; i < 3; i++) begin
      pc[i] = -1;
      pv[i] = -1;
    end
    for (int c = 1; c <= 1000 && np < 3; c++) begin
      vb = (v.gate ? (c % 2 == 1) : 1'b1) && (c != v.gap);
      step(pat_bit(v.pat, k), vb);
      if (vb) k++;
      if (out_valid) begin
        pc[np] = c;
        pv[np] = int'(out);
        if (np == 0) check($sformatf("v%0d settled@first", idx), int'(settled), 1);
        np++;
      end else if (np == 0 && settled) begin
        early = 1'b1;
      end
    end
    check($sformatf("v%0d settled early", idx), int'(early), 0);
    check($sformatf("v%0d pulse1 cycle", idx), pc[0], v.p1);
    check($sformatf("v%0d pulse2 cycle", idx), pc[1], v.p2);
    check($sformatf("v%0d pulse3 cycle", idx), pc[2], v.p3);
    for (int i = 0; i < 3; i++)
      check($sformatf("v%0d out%0d", idx, i), pv[i], v.val);
  endtask

  initial begin
    int np;

    vecs[0] = '{0, 1'b0, 0,   258, 322, 386,  262144};
    vecs[1] = '{1, 1'b0, 0,   258, 322, 386, -262144};
    vecs[2] = '{2, 1'b0, 0,   258, 322, 386,  0};
    vecs[3] = '{0, 1'b1, 0,   513, 641, 769,  262144};
    vecs[4] = '{0, 1'b0, 257, 258, 323, 387,  262144};
    vecs[5] = '{0, 1'b0, 100, 259, 323, 387,  262144};
    vecs[6] = '{3, 1'b0, 0,   258, 322, 386,  131072};
    vecs[7] = '{4, 1'b0, 0,   258, 322, 386, -131072};

    // Reset held with random input, then 3 frames produce no flagged sample.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bitstream_in    = 1'($urandom);
      bitstream_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    check("reset out", int'(out), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset settled", int'(settled), 0);
    reset = 1'b1;
    np = 0;
    for (int i = 0; i < 194; i++) begin
      step(1'b1, 1'b1);
      if (out_valid) np++;
    end
    check("discard pulses", np, 0);
    check("discard settled", int'(settled), 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset 10 clocks after the 5th pulse, then discard restarts.
    do_reset();
    np = 0;
    for (int i = 0; i < 524; i++) begin
      step(1'b1, 1'b1);
      if (out_valid) np++;
    end
    check("midop pulses", np, 5);
    check("midop settled before", int'(settled), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async out", int'(out), 0);
    check("async out_valid", int'(out_valid), 0);
    check("async settled", int'(settled), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    run_vec(8, vecs[0]);

    // Reset while the tick for a completed frame is still in the pipeline.
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      if (out_valid || out != 0) np++;
    end
    check("pending tick cancelled", np, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
